// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix-keypad scanner.
//   kp_state_t : scanner FSM states
//   key_code   : row/column to linear key code (row*n_cols+col)
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_t;

    function automatic int unsigned key_code(
        input int unsigned row,
        input int unsigned col,
        input int unsigned n_cols
    );
        return row * n_cols + col;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk    : destination clock
//   reset  : synchronous, active-high; loads RESET_VAL into both stages
//   i_d    : asynchronous input bus
//   o_q    : synchronised output, two clk cycles behind i_d
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix-keypad scanner for an N_ROWS x N_COLS active-low keypad.
// Drives one row low at a time, samples synchronised columns, debounces
// press and release, and keeps a two-deep history of accepted key codes.
//   clk       : system clock
//   reset     : synchronous, active-high
//   cols_n    : column sense, active-low, asynchronous
//   rows_n    : row drive, active-low, exactly one bit low
//   pressed   : a debounced key is currently held
//   key_valid : one-cycle strobe on each accepted press
//   new_value : most recent accepted key code
//   old_value : key code accepted before new_value
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter  int N_ROWS          = 4,
    parameter  int N_COLS          = 4,
    parameter  int SCAN_DIV        = 1000,
    parameter  int DEBOUNCE_CYCLES = 20000,
    localparam int KEY_W           = $clog2(N_ROWS * N_COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_COLS-1:0] cols_n,
    output logic [N_ROWS-1:0] rows_n,
    output logic              pressed,
    output logic              key_valid,
    output logic [KEY_W-1:0]  new_value,
    output logic [KEY_W-1:0]  old_value
);

    localparam int ROW_W = $clog2(N_ROWS);
    localparam int COL_W = $clog2(N_COLS);
    localparam int DW_W  = $clog2(SCAN_DIV);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(N_ROWS - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_COLS-1:0] w_cols_sync;
    logic [N_COLS-1:0] w_cols_s;

    kp_state_t         r_state;
    kp_state_t         w_state_nxt;
    logic [ROW_W-1:0]  r_row;
    logic [ROW_W-1:0]  w_row_inc;
    logic [DW_W-1:0]   r_dwell;
    logic [CNT_W-1:0]  r_cnt;
    logic [ROW_W-1:0]  r_cand_row;
    logic [COL_W-1:0]  r_cand_col;
    logic              r_pressed;
    logic              r_key_valid;
    logic [KEY_W-1:0]  r_new;
    logic [KEY_W-1:0]  r_old;

    logic [COL_W-1:0]  w_low_col;
    logic              w_any_col;
    logic              w_dwell_done;
    logic              w_cand_hit;
    logic              w_cnt_done;
    logic [KEY_W-1:0]  w_key;

    // Idle columns are pulled high, so the synchroniser resets to all-ones.
    sync_2ff #(
        .WIDTH     (N_COLS),
        .RESET_VAL ({N_COLS{1'b1}})
    ) u_cols_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (cols_n),
        .o_q   (w_cols_sync)
    );

    assign w_cols_s     = ~w_cols_sync;
    assign w_any_col    = |w_cols_s;
    assign w_dwell_done = (r_dwell == DWELL_LAST);
    assign w_cand_hit   = w_cols_s[r_cand_col];
    assign w_cnt_done   = (r_cnt == CNT_LAST);
    assign w_row_inc    = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
    assign w_key        = KEY_W'(key_code(32'(r_cand_row), 32'(r_cand_col), N_COLS));

    // Descending walk so the lowest set column is the last one written.
    always_comb begin
        w_low_col = '0;
        for (int unsigned i = N_COLS; i > 0; i--) begin
            if (w_cols_s[i-1]) begin
                w_low_col = COL_W'(i - 1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SCAN: begin
                if (w_dwell_done && w_any_col) begin
                    w_state_nxt = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!w_cand_hit) begin
                    w_state_nxt = SCAN;
                end else if (w_cnt_done) begin
                    w_state_nxt = HELD;
                end
            end
            HELD: begin
                if (!w_cand_hit && w_cnt_done) begin
                    w_state_nxt = SCAN;
                end
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    // r_cnt serves as the press counter in DEBOUNCE and the release counter
    // in HELD; it is cleared on entry to each.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SCAN;
            r_row       <= '0;
            r_dwell     <= '0;
            r_cnt       <= '0;
            r_cand_row  <= '0;
            r_cand_col  <= '0;
            r_pressed   <= 1'b0;
            r_key_valid <= 1'b0;
            r_new       <= '0;
            r_old       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_key_valid <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (w_dwell_done) begin
                        r_dwell <= '0;
                        if (w_any_col) begin
                            r_cand_row <= r_row;
                            r_cand_col <= w_low_col;
                            r_cnt      <= '0;
                        end else begin
                            r_row <= w_row_inc;
                        end
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!w_cand_hit) begin
                        r_dwell <= '0;
                    end else if (w_cnt_done) begin
                        r_key_valid <= 1'b1;
                        r_old       <= r_new;
                        r_new       <= w_key;
                        r_pressed   <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (w_cand_hit) begin
                        r_cnt <= '0;
                    end else if (w_cnt_done) begin
                        r_pressed <= 1'b0;
                        r_dwell   <= '0;
                        r_row     <= w_row_inc;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rows_n    = ~(N_ROWS'(1) << r_row);
    assign pressed   = r_pressed;
    assign key_valid = r_key_valid;
    assign new_value = r_new;
    assign old_value = r_old;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (4x4, SCAN_DIV=4,
// DEBOUNCE_CYCLES=8). A behavioural keypad matrix pulls a column low when a
// held key sits on the currently driven row.
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  cols_n;
    logic [3:0]  rows_n;
    logic        pressed;
    logic        key_valid;
    logic [3:0]  new_value;
    logic [3:0]  old_value;

    logic [15:0] keys;
    int          n_cmp;
    int          n_err;
    int          n_strobes;
    logic        prev_kv;
    int          base;

    keypad_scanner #(
        .N_ROWS          (4),
        .N_COLS          (4),
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cols_n    (cols_n),
        .rows_n    (rows_n),
        .pressed   (pressed),
        .key_valid (key_valid),
        .new_value (new_value),
        .old_value (old_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cols_n = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !rows_n[r]) begin
                    cols_n[c] = 1'b0;
                end
            end
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            n_strobes++;
            check_val("kv_single_cycle", int'(prev_kv), 0);
        end
        prev_kv = (key_valid === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_kv(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            step();
            if (key_valid) break;
        end
        check_val(tag, int'(key_valid), 1);
    endtask

    task automatic wait_release(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            step();
            if (!pressed) break;
        end
        check_val(tag, int'(pressed), 0);
    endtask

    task automatic press_release(input int code);
        keys[code] = 1'b1;
        wait_kv("press_kv", 200);
        keys = '0;
        wait_release("press_rel", 60);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_strobes = 0;
        prev_kv = 1'b0;
        keys = '0;
        reset = 1'b1;

        // Reset state and idle row walk.
        repeat (3) step();
        reset = 1'b0;
        check_val("rst_rows", int'(rows_n), 4'b1110);
        check_val("rst_pressed", int'(pressed), 0);
        check_val("rst_kv", int'(key_valid), 0);
        check_val("rst_new", int'(new_value), 0);
        check_val("rst_old", int'(old_value), 0);
        repeat (4) step();
        check_val("walk_r1", int'(rows_n), 4'b1101);
        repeat (4) step();
        check_val("walk_r2", int'(rows_n), 4'b1011);
        repeat (4) step();
        check_val("walk_r3", int'(rows_n), 4'b0111);
        repeat (4) step();
        check_val("walk_r0", int'(rows_n), 4'b1110);
        check_val("walk_pressed", int'(pressed), 0);
        check_val("walk_strobes", n_strobes, 0);

        // Key (row2,col1) = 9, held, then released with exact release timing.
        base = n_strobes;
        keys[9] = 1'b1;
        wait_kv("k9_kv", 200);
        check_val("k9_new", int'(new_value), 9);
        check_val("k9_old", int'(old_value), 0);
        check_val("k9_pressed", int'(pressed), 1);
        check_val("k9_row_held", int'(rows_n), 4'b1011);
        step();
        check_val("k9_kv_drop", int'(key_valid), 0);
        repeat (30) step();
        check_val("k9_one_strobe", n_strobes - base, 1);
        check_val("k9_held_rows", int'(rows_n), 4'b1011);
        keys = '0;
        repeat (9) step();
        check_val("k9_still_pressed", int'(pressed), 1);
        step();
        check_val("k9_released", int'(pressed), 0);
        check_val("k9_next_row", int'(rows_n), 4'b0111);

        // Bouncing contact: toggles every 3 cycles, then settles pressed.
        base = n_strobes;
        for (int i = 0; i < 10; i++) begin
            keys[9] = ~keys[9];
            repeat (3) step();
        end
        check_val("bounce_no_strobe", n_strobes - base, 0);
        keys[9] = 1'b1;
        wait_kv("bounce_kv", 200);
        check_val("bounce_new", int'(new_value), 9);
        check_val("bounce_old", int'(old_value), 9);
        repeat (20) step();
        check_val("bounce_one_strobe", n_strobes - base, 1);
        keys = '0;
        wait_release("bounce_rel", 60);

        // History: 5, 15, 5, 5.
        base = n_strobes;
        press_release(5);
        check_val("seq5_new", int'(new_value), 5);
        check_val("seq5_old", int'(old_value), 9);
        press_release(15);
        check_val("seq15_new", int'(new_value), 15);
        check_val("seq15_old", int'(old_value), 5);
        press_release(5);
        press_release(5);
        check_val("rep5_new", int'(new_value), 5);
        check_val("rep5_old", int'(old_value), 5);
        check_val("seq_strobes", n_strobes - base, 4);

        // Two keys on row 0: lowest column wins; extra key while held ignored.
        base = n_strobes;
        keys[3] = 1'b1;
        keys[1] = 1'b1;
        wait_kv("multi_kv", 200);
        check_val("multi_new", int'(new_value), 1);
        check_val("multi_old", int'(old_value), 5);
        keys[6] = 1'b1;
        repeat (30) step();
        check_val("multi_strobes", n_strobes - base, 1);
        check_val("multi_new_kept", int'(new_value), 1);
        check_val("multi_pressed", int'(pressed), 1);
        keys = '0;
        wait_release("multi_rel", 60);

        // Latency from reset with key 0 pressed: DEBOUNCE entered at edge 4,
        // strobe exactly 8 edges later.
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        keys[0] = 1'b1;
        repeat (11) step();
        check_val("lat_before", int'(key_valid), 0);
        step();
        check_val("lat_at", int'(key_valid), 1);
        check_val("lat_new", int'(new_value), 0);
        check_val("lat_pressed", int'(pressed), 1);
        keys = '0;
        wait_release("lat_rel", 60);

        // Reset at debounce count 5 discards the candidate.
        reset = 1'b1;
        step();
        reset = 1'b0;
        keys[0] = 1'b1;
        base = n_strobes;
        repeat (9) step();
        reset = 1'b1;
        keys = '0;
        step();
        reset = 1'b0;
        check_val("mid_rst_pressed", int'(pressed), 0);
        check_val("mid_rst_kv", int'(key_valid), 0);
        check_val("mid_rst_new", int'(new_value), 0);
        check_val("mid_rst_old", int'(old_value), 0);
        check_val("mid_rst_rows", int'(rows_n), 4'b1110);
        repeat (4) step();
        check_val("mid_rst_walk", int'(rows_n), 4'b1101);
        repeat (16) step();
        check_val("mid_rst_no_strobe", n_strobes - base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
